// File: rtl/vc_pop_arbiter.sv
// VC0/VC1 pop arbiter with layer sequencing: strict VC0 priority bounded by a VC1
// anti-starvation limit, registered routing of each popped word to D0 or D1.
module vc_pop_arbiter #(
  parameter int DATA_WIDTH    = 6,
  parameter int DEST_BIT      = 4,
  parameter int UMBRAL_WIDTH  = 2,
  parameter int MAX_VC0_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_af_in,
  input  logic                    error_in,
  input  logic                    empty_vc0,
  input  logic                    empty_vc1,
  input  logic [DATA_WIDTH-1:0]   data_vc0,
  input  logic [DATA_WIDTH-1:0]   data_vc1,
  input  logic                    pause_d0,
  input  logic                    pause_d1,
  output logic                    pop_vc0,
  output logic                    pop_vc1,
  output logic                    push_d0,
  output logic                    push_d1,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [UMBRAL_WIDTH-1:0] umbral_af_out,
  output logic [2:0]              state,
  output logic                    idle_out,
  output logic                    error_out
);

  // state  | meaning
  // RESET  | first cycle after reset release
  // INIT   | threshold loaded every cycle while init=1
  // IDLE   | configured, both VCs empty
  // ACTIVE | arbitrating and popping
  // ERROR  | sticky fault, only reset exits
  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int CNT_W = $clog2(MAX_VC0_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_VC0_BURST);

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    push_d0_q, push_d1_q;
  logic                    push_d0_d, push_d1_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [UMBRAL_WIDTH-1:0] umbral_q, umbral_d;

  logic active;
  logic dest0, dest1;
  logic elig0, elig1;
  logic grant0, grant1;

  assign active = (state_q == S_ACTIVE) && !reset;
  assign dest0  = data_vc0[DEST_BIT];
  assign dest1  = data_vc1[DEST_BIT];
  // Pause is looked up per word: each head word is checked against its own destination.
  assign elig0  = active && !empty_vc0 && !(dest0 ? pause_d1 : pause_d0);
  assign elig1  = active && !empty_vc1 && !(dest1 ? pause_d1 : pause_d0);
  assign grant1 = elig1 && (!elig0 || (cnt_q == CNT_MAX));
  assign grant0 = elig0 && !grant1;

  always_comb begin
    cnt_d = cnt_q;
    if (grant1 || !elig1) begin
      cnt_d = '0;
    end else if (grant0 && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE: begin
        if (error_in)                     state_d = S_ERROR;
        else if (init)                    state_d = S_INIT;
        else if (!empty_vc0 || !empty_vc1) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        // Wait for the last in-flight push to drain before dropping to IDLE.
        if (error_in)
          state_d = S_ERROR;
        else if (empty_vc0 && empty_vc1 && !push_d0_q && !push_d1_q)
          state_d = S_IDLE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
  end

  always_comb begin
    push_d0_d = (grant0 && !dest0) || (grant1 && !dest1);
    push_d1_d = (grant0 && dest0) || (grant1 && dest1);
    data_d    = data_q;
    if (grant0)      data_d = data_vc0;
    else if (grant1) data_d = data_vc1;
    umbral_d = (state_q == S_INIT) ? umbral_af_in : umbral_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
      umbral_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_q    <= data_d;
      umbral_q  <= umbral_d;
    end
  end

  assign pop_vc0       = grant0;
  assign pop_vc1       = grant1;
  assign push_d0       = push_d0_q;
  assign push_d1       = push_d1_q;
  assign data_out      = data_q;
  assign umbral_af_out = umbral_q;
  assign state         = state_q;
  assign idle_out      = (state_q == S_IDLE);
  assign error_out     = (state_q == S_ERROR);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: sequencing, priority/burst pattern, pause,
// error stickiness and asynchronous reset.
module tb_vc_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset, init, error_in;
  logic [1:0] umbral_af_in;
  logic       empty_vc0, empty_vc1;
  logic [5:0] data_vc0, data_vc1;
  logic       pause_d0, pause_d1;
  logic       pop_vc0, pop_vc1, push_d0, push_d1;
  logic [5:0] data_out;
  logic [1:0] umbral_af_out;
  logic [2:0] state;
  logic       idle_out, error_out;

  int total = 0;
  int bad   = 0;

  vc_pop_arbiter dut (
    .clk(clk), .reset(reset), .init(init), .umbral_af_in(umbral_af_in),
    .error_in(error_in), .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1), .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .umbral_af_out(umbral_af_out), .state(state),
    .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bring_up();
    reset = 1'b1; init = 1'b1; umbral_af_in = 2'd3; error_in = 1'b0;
    empty_vc0 = 1'b1; empty_vc1 = 1'b1; data_vc0 = '0; data_vc1 = '0;
    pause_d0 = 1'b0; pause_d1 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    // 1: reset and init sequencing
    reset = 1'b1; init = 1'b1; umbral_af_in = 2'd3; error_in = 1'b0;
    empty_vc0 = 1'b0; empty_vc1 = 1'b0; data_vc0 = 6'h05; data_vc1 = 6'h02;
    pause_d0 = 1'b0; pause_d1 = 1'b0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_pops", {pop_vc0, pop_vc1}, 0);
    chk("rst_push", {push_d0, push_d1}, 0);
    chk("rst_data", data_out, 0);
    chk("rst_umbral", umbral_af_out, 0);
    chk("rst_flags", {idle_out, error_out}, 0);
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    reset = 1'b0;
    tick();
    chk("init_state", state, 1);
    tick();
    chk("init_hold", state, 1);
    chk("init_umbral", umbral_af_out, 3);
    init = 1'b0;
    tick();
    chk("idle_state", state, 2);
    chk("idle_out", idle_out, 1);

    // 2: single VC0 word to D0
    empty_vc0 = 1'b0; data_vc0 = 6'h05;
    tick();
    chk("act_state", state, 3);
    chk("t2_pops", {pop_vc0, pop_vc1}, 2'b10);
    tick();
    empty_vc0 = 1'b1;
    chk("t2_push", {push_d0, push_d1}, 2'b10);
    chk("t2_data", data_out, 6'h05);
    tick();
    chk("t2_nopush", {push_d0, push_d1}, 0);
    chk("t2_hold", data_out, 6'h05);
    tick();
    tick();
    chk("t2_back_idle", state, 2);

    // 3: both VCs busy -> 4x VC0, 1x VC1 repeating
    empty_vc0 = 1'b0; empty_vc1 = 1'b0; data_vc0 = 6'h01; data_vc1 = 6'h22;
    tick();
    chk("t3_active", state, 3);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_grant%0d", i), {pop_vc0, pop_vc1}, (i % 5 == 4) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("t3_data%0d", i), data_out, (i % 5 == 4) ? 6'h22 : 6'h01);
      chk($sformatf("t3_push%0d", i), {push_d0, push_d1}, 2'b10);
    end

    // 4: VC0 head blocked by pause on D1, VC1 goes to D0
    data_vc0 = 6'h10; data_vc1 = 6'h02; pause_d1 = 1'b1;
    #1;
    chk("t4_pops", {pop_vc0, pop_vc1}, 2'b01);
    tick();
    chk("t4_push", {push_d0, push_d1}, 2'b10);
    chk("t4_data", data_out, 6'h02);

    // 5: error in ACTIVE; in-flight word still pushed, then sticky ERROR
    pause_d1 = 1'b0; error_in = 1'b1;
    #1;
    chk("t5_lastpop", {pop_vc0, pop_vc1}, 2'b10);
    tick();
    chk("t5_state", state, 4);
    chk("t5_errout", error_out, 1);
    chk("t5_inflight", {push_d1, data_out}, {1'b1, 6'h10});
    chk("t5_pops", {pop_vc0, pop_vc1}, 0);
    error_in = 1'b0; init = 1'b1;
    tick();
    chk("t5_sticky", state, 4);
    chk("t5_pops2", {pop_vc0, pop_vc1}, 0);
    chk("t5_nopush", {push_d0, push_d1}, 0);

    // 6: reset right after a pop drops the pending push
    bring_up();
    chk("t6_idle", state, 2);
    empty_vc0 = 1'b0; data_vc0 = 6'h05;
    tick();
    chk("t6_pop", pop_vc0, 1);
    tick();
    chk("t6_push", push_d0, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_push", {push_d0, push_d1}, 0);
    chk("t6_async_state", state, 0);
    chk("t6_async_pops", {pop_vc0, pop_vc1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
